// File: rtl/dror_point_feeder_if.sv
// Signal bundle between the DROR point feeder and its point memory, validator core and result consumer.
interface dror_point_feeder_if #(
  parameter int N                = 16,
  parameter int DISTANCE_MODULES = 8,
  parameter int ADDR_W           = 16
);
  logic                          i_start;
  logic [ADDR_W-1:0]             i_cloud_size;
  logic                          o_mem_rd_en;
  logic [ADDR_W-1:0]             o_mem_addr;
  logic [3*N-1:0]                i_mem_rdata;
  logic                          o_core_reset;
  logic [N-1:0]                  o_point_x;
  logic [N-1:0]                  o_point_y;
  logic [N-1:0]                  o_point_z;
  logic [N*DISTANCE_MODULES-1:0] o_cp_x;
  logic [N*DISTANCE_MODULES-1:0] o_cp_y;
  logic [N*DISTANCE_MODULES-1:0] o_cp_z;
  logic                          o_cp_valid;
  logic                          i_inlier;
  logic                          o_result_valid;
  logic [ADDR_W-1:0]             o_result_index;
  logic                          o_result_inlier;
  logic                          o_busy;
  logic                          o_done;

  modport master (
    input  i_start, i_cloud_size, i_mem_rdata, i_inlier,
    output o_mem_rd_en, o_mem_addr, o_core_reset,
           o_point_x, o_point_y, o_point_z,
           o_cp_x, o_cp_y, o_cp_z, o_cp_valid,
           o_result_valid, o_result_index, o_result_inlier,
           o_busy, o_done
  );

  modport slave (
    output i_start, i_cloud_size, i_mem_rdata, i_inlier,
    input  o_mem_rd_en, o_mem_addr, o_core_reset,
           o_point_x, o_point_y, o_point_z,
           o_cp_x, o_cp_y, o_cp_z, o_cp_valid,
           o_result_valid, o_result_index, o_result_inlier,
           o_busy, o_done
  );
endinterface

// File: rtl/dror_point_feeder.sv
// DROR point feeder: presents each point with batches of comparison lanes to the validator and classifies it.
// Build macro DROR_FEEDER_EARLY_EXIT_EN: abandon a point's remaining batches once it is known to be an inlier.
module dror_point_feeder #(
  parameter int N                = 16,
  parameter int DISTANCE_MODULES = 8,
  parameter int ADDR_W           = 16,
  parameter int CORE_LATENCY     = 4
) (
  input  logic                i_clock,
  input  logic                i_reset,
  dror_point_feeder_if.master bus
);
  localparam int DM    = DISTANCE_MODULES;
  localparam int CNT_W = $clog2(DM + CORE_LATENCY + 2);
  localparam logic [N-1:0] SENTINEL = {N{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_PT, S_CLR, S_FILL, S_PRESENT, S_DRAIN, S_REPORT, S_FIN
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] size_q;
  logic [ADDR_W-1:0] pt_idx;
  logic [ADDR_W:0]   batch_base;
  logic [CNT_W-1:0]  cnt;
  logic              sticky;
  logic [N-1:0]      point_x, point_y, point_z;
  logic [N*DM-1:0]   shadow_x, shadow_y, shadow_z;
  logic              fill_vld_p1;
  logic [CNT_W-1:0]  fill_lane_p1;

  logic [ADDR_W:0]   lane_idx, next_base, pt_next;
  logic              lane_real;

  // Lane indices are one bit wider than addresses so the last batch base cannot wrap.
  assign lane_idx  = batch_base + (ADDR_W+1)'(cnt);
  assign next_base = batch_base + (ADDR_W+1)'(DM);
  assign pt_next   = {1'b0, pt_idx} + (ADDR_W+1)'(1);
  assign lane_real = (cnt < CNT_W'(DM)) && (lane_idx < {1'b0, size_q})
                     && (lane_idx != {1'b0, pt_idx});

  always_ff @(posedge i_clock) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (bus.i_start) state_nxt = (bus.i_cloud_size == '0) ? S_FIN : S_LOAD_PT;
      S_LOAD_PT: if (cnt == CNT_W'(1)) state_nxt = S_CLR;
      S_CLR:     state_nxt = S_FILL;
      S_FILL:    if (cnt == CNT_W'(DM)) state_nxt = S_PRESENT;
      S_PRESENT: state_nxt = (next_base >= {1'b0, size_q}) ? S_DRAIN : S_FILL;
      S_DRAIN:   if (cnt == CNT_W'(CORE_LATENCY-1)) state_nxt = S_REPORT;
      S_REPORT:  state_nxt = (pt_next == {1'b0, size_q}) ? S_FIN : S_LOAD_PT;
      S_FIN:     state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
`ifdef DROR_FEEDER_EARLY_EXIT_EN
    if ((state == S_FILL || state == S_PRESENT) && (sticky || bus.i_inlier))
      state_nxt = S_REPORT;
`endif
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cnt         <= '0;
      size_q      <= '0;
      pt_idx      <= '0;
      batch_base  <= '0;
      sticky      <= 1'b0;
      fill_vld_p1 <= 1'b0;
      point_x     <= '0;
      point_y     <= '0;
      point_z     <= '0;
    end else begin
      cnt         <= (state_nxt != state) ? '0 : cnt + CNT_W'(1);
      fill_vld_p1 <= (state == S_FILL) && lane_real;
      case (state)
        S_IDLE: if (bus.i_start) begin
          size_q <= bus.i_cloud_size;
          pt_idx <= '0;
        end
        S_LOAD_PT: if (cnt == CNT_W'(1)) begin
          point_x <= bus.i_mem_rdata[N-1:0];
          point_y <= bus.i_mem_rdata[2*N-1:N];
          point_z <= bus.i_mem_rdata[3*N-1:2*N];
        end
        S_CLR: begin
          batch_base <= '0;
          sticky     <= 1'b0;
        end
        S_FILL, S_DRAIN: if (bus.i_inlier) sticky <= 1'b1;
        S_PRESENT: begin
          batch_base <= next_base;
          if (bus.i_inlier) sticky <= 1'b1;
        end
        S_REPORT: if (pt_next != {1'b0, size_q}) pt_idx <= pt_next[ADDR_W-1:0];
        default: ;
      endcase
    end
  end

  // _p1: read data returns one cycle after its strobe and lands in the lane it was issued for;
  // lanes with no read are filled with SENTINEL in the issue cycle itself.
  always_ff @(posedge i_clock) begin
    fill_lane_p1 <= cnt;
    if (state == S_FILL && cnt < CNT_W'(DM) && !lane_real) begin
      shadow_x[cnt*N +: N] <= SENTINEL;
      shadow_y[cnt*N +: N] <= SENTINEL;
      shadow_z[cnt*N +: N] <= SENTINEL;
    end
    if (fill_vld_p1) begin
      shadow_x[fill_lane_p1*N +: N] <= bus.i_mem_rdata[N-1:0];
      shadow_y[fill_lane_p1*N +: N] <= bus.i_mem_rdata[2*N-1:N];
      shadow_z[fill_lane_p1*N +: N] <= bus.i_mem_rdata[3*N-1:2*N];
    end
  end

  always_comb begin
    bus.o_mem_rd_en = 1'b0;
    bus.o_mem_addr  = '0;
    if (state == S_LOAD_PT && cnt == '0) begin
      bus.o_mem_rd_en = 1'b1;
      bus.o_mem_addr  = pt_idx;
    end else if (state == S_FILL && lane_real) begin
      bus.o_mem_rd_en = 1'b1;
      bus.o_mem_addr  = lane_idx[ADDR_W-1:0];
    end
    bus.o_core_reset    = (state == S_CLR);
    bus.o_point_x       = point_x;
    bus.o_point_y       = point_y;
    bus.o_point_z       = point_z;
    bus.o_cp_valid      = (state == S_PRESENT);
    bus.o_cp_x          = (state == S_PRESENT) ? shadow_x : {DM{SENTINEL}};
    bus.o_cp_y          = (state == S_PRESENT) ? shadow_y : {DM{SENTINEL}};
    bus.o_cp_z          = (state == S_PRESENT) ? shadow_z : {DM{SENTINEL}};
    bus.o_result_valid  = (state == S_REPORT);
    bus.o_result_index  = (state == S_REPORT) ? pt_idx : '0;
    bus.o_result_inlier = (state == S_REPORT) && sticky;
    bus.o_busy          = (state != S_IDLE) && (state != S_FIN);
    bus.o_done          = (state == S_FIN);
  end
endmodule

// File: tb/tb_dror_point_feeder.sv
// Scoreboard bench for dror_point_feeder with a behavioural point memory and validator stand-in.
`timescale 1ns/1ps
module tb_dror_point_feeder;
  localparam int N  = 16;
  localparam int DM = 8;
  localparam int AW = 16;
  localparam int CL = 4;
  localparam int K  = 5;   // neighbours needed to be an inlier
  localparam int R  = 2;   // per-axis neighbour radius
  localparam logic [N-1:0] SENT = {N{1'b1}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dror_point_feeder_if #(.N(N), .DISTANCE_MODULES(DM), .ADDR_W(AW)) bus ();

  dror_point_feeder #(.N(N), .DISTANCE_MODULES(DM), .ADDR_W(AW), .CORE_LATENCY(CL)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  typedef struct { int idx; bit inl; } exp_t;
  exp_t exp_q[$];

  logic [3*N-1:0] mem [0:63];
  int total = 0;
  int bad = 0;
  int rd_cnt, cp_cnt, res_cnt, cur_pt, bat, mon_size;
  logic [CL-1:0] pipe;
  int vcount;
  logic [N*DM-1:0] ex, ey, ez;

  task automatic check(string name, logic [383:0] got, logic [383:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic logic [3*N-1:0] pt(int x, int y, int z);
    return {N'(z), N'(y), N'(x)};
  endfunction

  function automatic bit near(logic [3*N-1:0] a, logic [3*N-1:0] b);
    for (int c = 0; c < 3; c++) begin
      int d;
      d = int'(a[c*N +: N]) - int'(b[c*N +: N]);
      if (d > R || d < -R) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic bit exp_inlier(int i, int sz);
    int n = 0;
    for (int j = 0; j < sz; j++)
      if (j != i && near(mem[i], mem[j])) n++;
    return n >= K;
  endfunction

  // Point memory: one-cycle read latency.
  always @(posedge clk)
    if (bus.o_mem_rd_en) bus.i_mem_rdata <= mem[bus.o_mem_addr[5:0]];

  // Validator stand-in: cumulative neighbour count, flag delayed by CL cycles.
  always @(posedge clk) begin
    int nc;
    if (rst || bus.o_core_reset) begin
      vcount <= 0;
      pipe   <= '0;
    end else begin
      nc = vcount;
      if (bus.o_cp_valid)
        for (int k = 0; k < DM; k++)
          if (bus.o_cp_x[k*N +: N] != SENT &&
              near({bus.o_cp_z[k*N +: N], bus.o_cp_y[k*N +: N], bus.o_cp_x[k*N +: N]},
                   {bus.o_point_z, bus.o_point_y, bus.o_point_x}))
            nc++;
      vcount <= nc;
      pipe   <= {pipe[CL-2:0], nc >= K};
    end
  end
  assign bus.i_inlier = pipe[CL-1];

  // Monitor: lane contents, point register, read range and result stream.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_mem_rd_en) begin
        rd_cnt++;
        check("rd_addr_range", int'(bus.o_mem_addr) < mon_size, 1);
      end
      if (bus.o_cp_valid) begin
        for (int k = 0; k < DM; k++) begin
          int idx;
          idx = bat * DM + k;
          if (idx >= mon_size || idx == cur_pt) begin
            ex[k*N +: N] = SENT;
            ey[k*N +: N] = SENT;
            ez[k*N +: N] = SENT;
          end else begin
            ex[k*N +: N] = mem[idx][N-1:0];
            ey[k*N +: N] = mem[idx][2*N-1:N];
            ez[k*N +: N] = mem[idx][3*N-1:2*N];
          end
        end
        check("cp_lanes", {bus.o_cp_z, bus.o_cp_y, bus.o_cp_x}, {ez, ey, ex});
        check("point_reg", {bus.o_point_z, bus.o_point_y, bus.o_point_x}, mem[cur_pt[5:0]]);
        cp_cnt++;
        bat++;
      end
      if (bus.o_result_valid) begin
        res_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL result_extra: got index %0d, want no result", bus.o_result_index);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("result_index", bus.o_result_index, e.idx);
          check("result_inlier", bus.o_result_inlier, e.inl);
        end
        cur_pt++;
        bat = 0;
      end
    end
  end

  task automatic start_pass(int sz);
    exp_t e;
    mon_size = sz;
    cur_pt = 0; bat = 0; cp_cnt = 0; rd_cnt = 0; res_cnt = 0;
    for (int i = 0; i < sz; i++) begin
      e.idx = i;
      e.inl = exp_inlier(i, sz);
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_cloud_size = AW'(sz);
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_cloud_size = AW'(sz + 5);
  endtask

  task automatic wait_done(string name, int budget, int exp_batches, bit poke);
    bit seen = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (bus.o_done) begin
        seen = 1'b1;
        break;
      end
      if (poke && c == 30) begin
        bus.i_start = 1'b1;
        bus.i_cloud_size = AW'(2);
      end
      if (poke && c == 31) bus.i_start = 1'b0;
      @(negedge clk);
    end
    bus.i_start = 1'b0;
    check({name, "_done_seen"}, seen, 1);
    check({name, "_busy_at_done"}, bus.o_busy, 0);
    check({name, "_result_count"}, res_cnt, mon_size);
    check({name, "_queue_empty"}, exp_q.size(), 0);
    if (exp_batches >= 0) check({name, "_batches"}, cp_cnt, exp_batches);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.i_start = 1'b0;
    bus.i_cloud_size = '0;
    mon_size = 0; cur_pt = 0; bat = 0; cp_cnt = 0; rd_cnt = 0; res_cnt = 0;
    for (int i = 0; i < 64; i++) mem[i] = '0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.o_busy, 0);
    check("rst_done", bus.o_done, 0);
    check("rst_cp_valid", bus.o_cp_valid, 0);
    check("rst_cp_lanes", {bus.o_cp_z, bus.o_cp_y, bus.o_cp_x}, {(3*DM){SENT}});
    check("rst_result_valid", bus.o_result_valid, 0);
    check("rst_rd_en", bus.o_mem_rd_en, 0);
    check("rst_core_reset", bus.o_core_reset, 0);
    check("rst_point", {bus.o_point_z, bus.o_point_y, bus.o_point_x}, 0);
    rst = 1'b0;

    // Empty cloud: straight to done, no reads.
    start_pass(0);
    wait_done("size0", 3, 0, 1'b0);
    check("size0_reads", rd_cnt, 0);

    // Single point: one all-sentinel batch, outlier.
    mem[0] = pt(7, 8, 9);
    start_pass(1);
    wait_done("size1", 200, 1, 1'b0);
    check("size1_reads", rd_cnt, 1);

    // Six coincident points plus three isolated ones; a stray start mid-pass is ignored.
    for (int i = 0; i < 6; i++) mem[i] = pt(100, 100, 100);
    mem[6] = pt(1000, 5, 5);
    mem[7] = pt(5, 2000, 5);
    mem[8] = pt(5, 5, 3000);
    start_pass(9);
`ifdef DROR_FEEDER_EARLY_EXIT_EN
    wait_done("cluster9", 3000, -1, 1'b1);
`else
    wait_done("cluster9", 3000, 18, 1'b1);
`endif

    // Near-but-not-identical cluster of 7 and a small group of 3 that second batches must reach.
    for (int i = 0; i < 7; i++) mem[i] = pt(50 + i % 3, 60 + i % 2, 70);
    for (int i = 7; i < 10; i++) mem[i] = pt(500 + i - 7, 600, 700);
    start_pass(10);
`ifdef DROR_FEEDER_EARLY_EXIT_EN
    wait_done("mixed10", 3000, -1, 1'b0);
`else
    wait_done("mixed10", 3000, 20, 1'b0);
`endif

    // Thirty-two identical points.
    for (int i = 0; i < 32; i++) mem[i] = pt(300, 300, 300);
    start_pass(32);
`ifdef DROR_FEEDER_EARLY_EXIT_EN
    wait_done("ident32", 6000, 32, 1'b0);
`else
    wait_done("ident32", 6000, 128, 1'b0);
`endif

    // Reset during the fill of point 3, then a clean rerun.
    for (int i = 0; i < 6; i++) mem[i] = pt(100, 100, 100);
    mem[6] = pt(1000, 5, 5);
    mem[7] = pt(5, 2000, 5);
    mem[8] = pt(5, 5, 3000);
    start_pass(9);
    n = 0;
    for (int c = 0; c < 3000; c++) begin
      if (bus.o_core_reset) n++;
      if (n == 4) break;
      @(negedge clk);
    end
    check("midrst_reached_pt3", n, 4);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", bus.o_busy, 0);
    check("midrst_done", bus.o_done, 0);
    check("midrst_result_valid", bus.o_result_valid, 0);
    check("midrst_core_reset", bus.o_core_reset, 0);
    check("midrst_results_before", res_cnt, 3);
    rst = 1'b0;
    exp_q.delete();
    start_pass(9);
`ifdef DROR_FEEDER_EARLY_EXIT_EN
    wait_done("rerun9", 3000, -1, 1'b0);
`else
    wait_done("rerun9", 3000, 18, 1'b0);
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
